xy_output_arbiter: RTL and testbench

//  Per-output-port scheduler for the XY switch: shares one switch output among PORT_N input FIFO heads.

---
 rtl/xy_output_arbiter.sv | 161 ++++++++++++++++
 tb/tb_xy_output_arbiter.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/xy_output_arbiter.sv
// Per-output-port scheduler: round-robin or fixed-priority arbitration over PORT_N FIFO heads, with burst hold up to MAX_BURST.
// Optional `ARB_PERF_CNT_EN adds stall_cnt_o (saturating count of cycles with pending requests blocked by a full downstream FIFO).
module xy_output_arbiter #(
  parameter int PORT_N      = 5,
  parameter int PACKET_W    = 16,
  parameter int ARB_TYPE    = 0,
  parameter int MAX_BURST   = 4,
  parameter int BURST_CNT_W = 3
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic [PORT_N-1:0]          req_i,
  input  logic [PACKET_W*PORT_N-1:0] pckt_i,
  output logic [PORT_N-1:0]          rd_en_o,
  input  logic                       nxt_fifo_full_i,
  output logic                       wr_en_o,
  output logic [PACKET_W-1:0]        pckt_o,
  output logic [PORT_N-1:0]          grant_o
`ifdef ARB_PERF_CNT_EN
  ,
  output logic [15:0]                stall_cnt_o
`endif
);

  localparam int IDX_W = (PORT_N > 1) ? $clog2(PORT_N) : 1;

  typedef enum logic {IDLE, HOLD} state_e;

  state_e                 state_q, state_d;
  logic [IDX_W-1:0]       owner_q, owner_d;
  logic [IDX_W-1:0]       ptr_q, ptr_d;
  logic [BURST_CNT_W-1:0] cnt_q, cnt_d;
  logic [PORT_N-1:0]      grant_q, grant_d;
  logic                   wr_en_q, wr_en_d;
  logic [PACKET_W-1:0]    pckt_q, pckt_d;

  logic [IDX_W-1:0]       owner_nxt, arb_base, win, xfer_idx;
  logic [PORT_N-1:0]      win_oh, rd_en;
  logic [PACKET_W-1:0]    pckt_sel;
  logic                   found, xfer;

  assign owner_nxt = IDX_W'((int'(owner_q) + 1) % PORT_N);

  // On release the scan starts just past the owner, so the owner can only re-win when alone.
  assign arb_base = (ARB_TYPE == 1) ? '0 : ((state_q == HOLD) ? owner_nxt : ptr_q);

  always_comb begin
    logic [IDX_W-1:0] idx;
    idx   = '0;
    found = 1'b0;
    win   = '0;
    for (int i = 0; i < PORT_N; i++) begin
      idx = IDX_W'((int'(arb_base) + i) % PORT_N);
      if (!found && req_i[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
  end

  always_comb begin
    win_oh   = '0;
    rd_en    = '0;
    pckt_sel = '0;
    for (int k = 0; k < PORT_N; k++) begin
      win_oh[k] = (int'(win) == k);
      rd_en[k]  = xfer && (int'(xfer_idx) == k);
      if (int'(xfer_idx) == k) pckt_sel = pckt_i[k*PACKET_W +: PACKET_W];
    end
  end

  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    cnt_d    = cnt_q;
    ptr_d    = ptr_q;
    grant_d  = grant_q;
    xfer     = 1'b0;
    xfer_idx = owner_q;
    unique case (state_q)
      IDLE: begin
        if (!nxt_fifo_full_i && found) begin
          xfer     = 1'b1;
          xfer_idx = win;
          state_d  = HOLD;
          owner_d  = win;
          cnt_d    = BURST_CNT_W'(1);
          grant_d  = win_oh;
          ptr_d    = IDX_W'((int'(win) + 1) % PORT_N);
        end
      end
      HOLD: begin
        if (req_i[owner_q] && (cnt_q < BURST_CNT_W'(MAX_BURST))) begin
          if (!nxt_fifo_full_i) begin
            xfer  = 1'b1;
            cnt_d = cnt_q + BURST_CNT_W'(1);
          end
        end else begin
          ptr_d = owner_nxt;
          if (!nxt_fifo_full_i && found) begin
            xfer     = 1'b1;
            xfer_idx = win;
            owner_d  = win;
            cnt_d    = BURST_CNT_W'(1);
            grant_d  = win_oh;
          end else begin
            state_d = IDLE;
            grant_d = '0;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign wr_en_d = xfer;
  assign pckt_d  = xfer ? pckt_sel : pckt_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      owner_q <= '0;
      ptr_q   <= '0;
      cnt_q   <= '0;
      grant_q <= '0;
      wr_en_q <= 1'b0;
      pckt_q  <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      grant_q <= grant_d;
      wr_en_q <= wr_en_d;
      pckt_q  <= pckt_d;
    end
  end

  // Pop strobe is combinational, so it is gated while reset is held.
  assign rd_en_o = rst_ni ? rd_en : '0;
  assign wr_en_o = wr_en_q;
  assign pckt_o  = pckt_q;
  assign grant_o = grant_q;

`ifdef ARB_PERF_CNT_EN
  logic [15:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if ((|req_i) && nxt_fifo_full_i && (stall_cnt_q != 16'hFFFF)) stall_cnt_d = stall_cnt_q + 16'd1;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) stall_cnt_q <= '0;
    else         stall_cnt_q <= stall_cnt_d;
  end

  assign stall_cnt_o = stall_cnt_q;
`endif

endmodule

// File: tb/tb_xy_output_arbiter.sv
// Directed bench for xy_output_arbiter: round-robin instance plus a fixed-priority instance.
module tb_xy_output_arbiter;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic [4:0]  req_i, req_b;
  logic        full_i, full_b;
  logic [79:0] pckt_i;
  logic [4:0]  rd_en_o, rd_en_b;
  logic        wr_en_o, wr_en_b;
  logic [15:0] pckt_o, pckt_b;
  logic [4:0]  grant_o, grant_b;
`ifdef ARB_PERF_CNT_EN
  logic [15:0] stall_cnt_o, stall_cnt_b;
`endif

  int checks   = 0;
  int failures = 0;
  logic [15:0] pk [5];

  always #5 clk_i = ~clk_i;

  xy_output_arbiter #(.PORT_N(5), .PACKET_W(16), .ARB_TYPE(0), .MAX_BURST(4), .BURST_CNT_W(3)) u_rr (
    .clk_i(clk_i), .rst_ni(rst_ni), .req_i(req_i), .pckt_i(pckt_i), .rd_en_o(rd_en_o),
    .nxt_fifo_full_i(full_i), .wr_en_o(wr_en_o), .pckt_o(pckt_o), .grant_o(grant_o)
`ifdef ARB_PERF_CNT_EN
    , .stall_cnt_o(stall_cnt_o)
`endif
  );

  xy_output_arbiter #(.PORT_N(5), .PACKET_W(16), .ARB_TYPE(1), .MAX_BURST(4), .BURST_CNT_W(3)) u_fp (
    .clk_i(clk_i), .rst_ni(rst_ni), .req_i(req_b), .pckt_i(pckt_i), .rd_en_o(rd_en_b),
    .nxt_fifo_full_i(full_b), .wr_en_o(wr_en_b), .pckt_o(pckt_b), .grant_o(grant_b)
`ifdef ARB_PERF_CNT_EN
    , .stall_cnt_o(stall_cnt_b)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // One clock of stimulus: pop strobe checked before the edge, registered outputs #1 after it.
  task automatic cyc(input string tag, input bit use_b, input logic [4:0] req, input logic full,
                     input logic [4:0] exp_rd, input logic exp_wr, input logic [4:0] exp_gnt,
                     input logic [15:0] exp_pk);
    @(negedge clk_i);
    if (use_b) begin req_b = req; full_b = full; end
    else       begin req_i = req; full_i = full; end
    #1;
    chk({tag, ".rd"}, use_b ? rd_en_b : rd_en_o, exp_rd);
    @(posedge clk_i);
    #1;
    chk({tag, ".wr"},   use_b ? wr_en_b : wr_en_o, exp_wr);
    chk({tag, ".gnt"},  use_b ? grant_b : grant_o, exp_gnt);
    chk({tag, ".pckt"}, use_b ? pckt_b : pckt_o, exp_pk);
  endtask

  task automatic do_reset();
    rst_ni = 1'b0;
    req_i = '0; full_i = 1'b0; req_b = '0; full_b = 1'b0;
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    rst_ni = 1'b1;
  endtask

  initial begin
    int wr_cnt;
    int own;
    pk[0] = 16'h1000; pk[1] = 16'h1101; pk[2] = 16'h12AB; pk[3] = 16'h1303; pk[4] = 16'h1404;
    for (int k = 0; k < 5; k++) pckt_i[k*16 +: 16] = pk[k];

    // Reset state, with a pending request that must not pop.
    rst_ni = 1'b0; req_i = 5'b00100; full_i = 1'b0; req_b = '0; full_b = 1'b0;
    #12;
    chk("rst.rd",   rd_en_o, 5'b0);
    chk("rst.wr",   wr_en_o, 1'b0);
    chk("rst.gnt",  grant_o, 5'b0);
    chk("rst.pckt", pckt_o,  16'h0);
    do_reset();

    // Single requester, three packets, then drop.
    for (int i = 0; i < 3; i++) cyc("t1.burst", 0, 5'b00100, 1'b0, 5'b00100, 1'b1, 5'b00100, 16'h12AB);
    cyc("t1.drop", 0, 5'b00000, 1'b0, 5'b00000, 1'b0, 5'b00000, 16'h12AB);

    // Three requesters, bursts of four each in round-robin order.
    do_reset();
    wr_cnt = 0;
    for (int i = 0; i < 12; i++) begin
      own = (i < 4) ? 0 : ((i < 8) ? 1 : 4);
      cyc("t2.rr", 0, 5'b10011, 1'b0, 5'b00001 << own, 1'b1, 5'b00001 << own, pk[own]);
      if (wr_en_o) wr_cnt++;
    end
    chk("t2.writes", wr_cnt, 12);
    cyc("t2.drop", 0, 5'b00000, 1'b0, 5'b00000, 1'b0, 5'b00000, pk[4]);

    // Burst on port 1 stalled by downstream full mid-burst, then release to port 0.
    cyc("t3.p1", 0, 5'b00010, 1'b0, 5'b00010, 1'b1, 5'b00010, pk[1]);
    cyc("t3.p1", 0, 5'b00010, 1'b0, 5'b00010, 1'b1, 5'b00010, pk[1]);
    for (int i = 0; i < 3; i++) cyc("t3.stall", 0, 5'b00010, 1'b1, 5'b00000, 1'b0, 5'b00010, pk[1]);
    cyc("t3.resume", 0, 5'b00010, 1'b0, 5'b00010, 1'b1, 5'b00010, pk[1]);
    cyc("t3.resume", 0, 5'b00010, 1'b0, 5'b00010, 1'b1, 5'b00010, pk[1]);
    cyc("t3.release", 0, 5'b00011, 1'b0, 5'b00001, 1'b1, 5'b00001, pk[0]);
    cyc("t3.idle", 0, 5'b00000, 1'b0, 5'b00000, 1'b0, 5'b00000, pk[0]);

    // Asynchronous reset mid-burst on port 0; pointer must restart at 0.
    cyc("t5.p0", 0, 5'b00001, 1'b0, 5'b00001, 1'b1, 5'b00001, pk[0]);
    cyc("t5.p0", 0, 5'b00001, 1'b0, 5'b00001, 1'b1, 5'b00001, pk[0]);
    #2;
    rst_ni = 1'b0;
    #1;
    chk("t5.rst.wr",   wr_en_o, 1'b0);
    chk("t5.rst.gnt",  grant_o, 5'b0);
    chk("t5.rst.pckt", pckt_o,  16'h0);
    chk("t5.rst.rd",   rd_en_o, 5'b0);
    @(negedge clk_i);
    req_i = '0;
    rst_ni = 1'b1;
    cyc("t5.first", 0, 5'b00011, 1'b0, 5'b00001, 1'b1, 5'b00001, pk[0]);
    cyc("t5.idle", 0, 5'b00000, 1'b0, 5'b00000, 1'b0, 5'b00000, pk[0]);

    // Fixed priority: port 3 keeps its burst although port 0 arrives, then port 0 wins.
    cyc("t4.p3", 1, 5'b11000, 1'b0, 5'b01000, 1'b1, 5'b01000, pk[3]);
    for (int i = 0; i < 3; i++) cyc("t4.p3", 1, 5'b11001, 1'b0, 5'b01000, 1'b1, 5'b01000, pk[3]);
    cyc("t4.p0", 1, 5'b11001, 1'b0, 5'b00001, 1'b1, 5'b00001, pk[0]);
    cyc("t4.idle", 1, 5'b00000, 1'b0, 5'b00000, 1'b0, 5'b00000, pk[0]);

`ifdef ARB_PERF_CNT_EN
    do_reset();
    chk("t6.rst", stall_cnt_o, 16'd0);
    for (int i = 0; i < 10; i++) cyc("t6.stall", 0, 5'b00001, 1'b1, 5'b00000, 1'b0, 5'b00000, 16'h0);
    chk("t6.ten", stall_cnt_o, 16'd10);
    repeat (70000) @(posedge clk_i);
    #1;
    chk("t6.sat", stall_cnt_o, 16'hFFFF);
    @(negedge clk_i);
    req_i = '0; full_i = 1'b0;
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
